// File: rtl/tcnj_ahb_pkg.sv
// Shared AHB-lite encodings and the per-port state encoding for the SRAM bank arbiter.
// Also holds the transfer legality check and the byte-lane decode.
package tcnj_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    P_IDLE,
    P_WAIT,
    P_RDATA,
    P_ERR1,
    P_ERR2
  } port_state_e;

  // Sizes above a word, or misaligned halfword/word accesses, are rejected.
  function automatic logic xfer_legal(input logic [2:0] size, input logic [1:0] lsb);
    xfer_legal = (size == HSIZE_BYTE) ||
                 ((size == HSIZE_HALF) && !lsb[0]) ||
                 ((size == HSIZE_WORD) && (lsb == 2'b00));
  endfunction

  function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] lsb);
    case (size)
      HSIZE_BYTE: byte_lanes = 4'b0001 << lsb;
      HSIZE_HALF: byte_lanes = lsb[1] ? 4'b1100 : 4'b0011;
      default:    byte_lanes = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/sram_bank_arbiter_if.sv
// One AHB-lite slave port of the SRAM bank: address/data phase in, ready/response/read data out.
interface sram_bank_arbiter_if;
  logic        hsel;
  logic        hready_in;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hready_out;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, hready_in, haddr, hwrite, hsize, htrans, hwdata,
    input  hready_out, hresp, hrdata
  );

  modport slave (
    input  hsel, hready_in, haddr, hwrite, hsize, htrans, hwdata,
    output hready_out, hresp, hrdata
  );
endinterface

// File: rtl/sram_arb_port.sv
// Per-port address-phase capture, legality check and transfer FSM.
// Raises req while waiting for the SRAM and completes the transfer when granted.
module sram_arb_port
  import tcnj_ahb_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          hsel,
  input  logic          hready_in,
  input  logic [31:0]   haddr,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [1:0]    htrans,
  input  logic          grant,
  output logic          req,
  output logic          is_write,
  output logic [AW-1:0] addr,
  output logic [2:0]    size,
  output logic          hready_out,
  output logic          hresp,
  output logic          rdata_phase
);

  port_state_e   state_reg, state_next, accept_state;
  logic [AW-1:0] addr_reg;
  logic          write_reg;
  logic [2:0]    size_reg;
  logic          accept;
  logic          legal;
  logic          load;
  logic          unused_haddr;

  assign unused_haddr = ^haddr[31:AW];

  assign accept = hsel & htrans[1] & hready_in & hready_out;
  assign legal  = xfer_legal(hsize, haddr[1:0]);
  // The master cancels anything it presents during the second error cycle.
  assign load   = accept & (state_reg != P_ERR2);
  assign accept_state = !accept ? P_IDLE : (legal ? P_WAIT : P_ERR1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= P_IDLE;
      addr_reg  <= '0;
      write_reg <= 1'b0;
      size_reg  <= 3'b000;
    end else begin
      state_reg <= state_next;
      if (load) begin
        addr_reg  <= haddr[AW-1:0];
        write_reg <= hwrite;
        size_reg  <= hsize;
      end
    end
  end

  always_comb begin
    hready_out = 1'b1;
    hresp      = HRESP_OKAY;
    case (state_reg)
      P_WAIT:  hready_out = grant & write_reg;
      P_ERR1: begin
        hready_out = 1'b0;
        hresp      = HRESP_ERROR;
      end
      P_ERR2:  hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      P_IDLE:  state_next = accept_state;
      P_WAIT: begin
        if (grant) state_next = write_reg ? accept_state : P_RDATA;
      end
      P_RDATA: state_next = accept_state;
      P_ERR1:  state_next = P_ERR2;
      P_ERR2:  state_next = P_IDLE;
      default: state_next = P_IDLE;
    endcase
  end

  assign req         = (state_reg == P_WAIT);
  assign rdata_phase = (state_reg == P_RDATA);
  assign is_write    = write_reg;
  assign addr        = addr_reg;
  assign size        = size_reg;

endmodule

// File: rtl/sram_bank_arbiter.sv
// Shares one single-port SRAM bank between the IMEM (port 0) and DMEM (port 1) AHB-lite buses.
// Round-robin grant, byte-lane decode and read-data steering live here.
module sram_bank_arbiter
  import tcnj_ahb_pkg::*;
#(
  parameter int MEM_AW = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sram_bank_arbiter_if.slave   p0,
  sram_bank_arbiter_if.slave   p1,
  output logic                 sram_en,
  output logic                 sram_rwn,
  output logic [MEM_AW-1:0]    sram_addr,
  output logic [3:0]           sram_wben,
  output logic [31:0]          sram_wdata,
  input  logic [31:0]          sram_rdata
);

  localparam int AW = MEM_AW + 2;

  logic [1:0]    hsel, hready_in, hwrite, req, grant, is_write, hready_out, hresp, rdata_phase;
  logic [31:0]   haddr  [2];
  logic [31:0]   hwdata [2];
  logic [2:0]    hsize  [2];
  logic [1:0]    htrans [2];
  logic [2:0]    size   [2];
  logic [AW-1:0] addr   [2];
  logic          rr_last_reg;
  logic          gsel;

  assign hsel      = {p1.hsel, p0.hsel};
  assign hready_in = {p1.hready_in, p0.hready_in};
  assign hwrite    = {p1.hwrite, p0.hwrite};
  assign haddr[0]  = p0.haddr;
  assign haddr[1]  = p1.haddr;
  assign hwdata[0] = p0.hwdata;
  assign hwdata[1] = p1.hwdata;
  assign hsize[0]  = p0.hsize;
  assign hsize[1]  = p1.hsize;
  assign htrans[0] = p0.htrans;
  assign htrans[1] = p1.htrans;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      sram_arb_port #(.AW(AW)) u_port (
        .clk         (clk),
        .reset_n     (reset_n),
        .hsel        (hsel[gi]),
        .hready_in   (hready_in[gi]),
        .haddr       (haddr[gi]),
        .hwrite      (hwrite[gi]),
        .hsize       (hsize[gi]),
        .htrans      (htrans[gi]),
        .grant       (grant[gi]),
        .req         (req[gi]),
        .is_write    (is_write[gi]),
        .addr        (addr[gi]),
        .size        (size[gi]),
        .hready_out  (hready_out[gi]),
        .hresp       (hresp[gi]),
        .rdata_phase (rdata_phase[gi])
      );
    end
  endgenerate

  // On a tie the port that was not granted last wins.
  assign grant[0] = req[0] & (~req[1] | rr_last_reg);
  assign grant[1] = req[1] & (~req[0] | ~rr_last_reg);
  assign gsel     = grant[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_last_reg <= 1'b1;
    end else if (|grant) begin
      rr_last_reg <= gsel;
    end
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_rwn   = 1'b1;
    sram_addr  = '0;
    sram_wben  = 4'b0000;
    sram_wdata = 32'h0;
    if (|grant) begin
      sram_en   = 1'b1;
      sram_rwn  = ~is_write[gsel];
      sram_addr = addr[gsel][AW-1:2];
      if (is_write[gsel]) begin
        sram_wben  = byte_lanes(size[gsel], addr[gsel][1:0]);
        sram_wdata = hwdata[gsel];
      end
    end
  end

  assign p0.hready_out = hready_out[0];
  assign p1.hready_out = hready_out[1];
  assign p0.hresp      = hresp[0];
  assign p1.hresp      = hresp[1];
  assign p0.hrdata     = rdata_phase[0] ? sram_rdata : 32'h0;
  assign p1.hrdata     = rdata_phase[1] ? sram_rdata : 32'h0;

endmodule
